whack_judge: RTL and testbench



---
 rtl/whack_judge.sv | 137 +++++++++++++
 tb/tb_whack_judge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/whack_judge.sv
// Debounces the registered key stream into single press events and judges each
// press against the raised mole, keeping saturating hit and miss counters.
module whack_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NUM_HOLES       = 9,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         key,
  input  logic [3:0]         mole_pos,
  input  logic               mole_up,
  input  logic               clear,
  output logic               hit,
  output logic               miss,
  output logic [3:0]         last_key,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [3:0]       KEY_NONE = 4'd15;
  localparam logic [3:0]       HOLES    = 4'(NUM_HOLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             valid_c;
  logic             match_c;
  logic             fire_c;

  assign valid_c   = (key < HOLES);
  assign cnt_inc_c = cnt_q + CNT_ONE;
  // An event always fires on a valid sample equal to the candidate, so key names the press.
  assign match_c   = mole_up && (mole_pos < HOLES) && (mole_pos == key);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= KEY_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Press/release debounce and event strobe
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    fire_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_c) begin
          cand_d = key;
          cnt_d  = CNT_ONE;
          if (SINGLE) begin
            state_d = HELD;
            fire_c  = 1'b1;
          end else begin
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (!valid_c) begin
          state_d = IDLE;
        end else if (key == cand_q) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_MAX) begin
            state_d = HELD;
            fire_c  = 1'b1;
          end
        end else begin
          cand_d = key;
          cnt_d  = CNT_ONE;
        end
      end
      HELD: begin
        if (!valid_c) begin
          cnt_d   = CNT_ONE;
          state_d = SINGLE ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (valid_c) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_MAX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered judgement outputs; clear beats increment but not the pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit        <= 1'b0;
      miss       <= 1'b0;
      last_key   <= KEY_NONE;
      score      <= '0;
      miss_count <= '0;
    end else begin
      hit  <= fire_c && match_c;
      miss <= fire_c && !match_c;
      if (fire_c) last_key <= cand_d;
      if (clear) begin
        score <= '0;
      end else if (fire_c && match_c && (score != '1)) begin
        score <= score + SCORE_W'(1);
      end
      if (clear) begin
        miss_count <= '0;
      end else if (fire_c && !match_c && (miss_count != '1)) begin
        miss_count <= miss_count + SCORE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_whack_judge.sv
// Directed bench for whack_judge with N=4 debounce and 2-bit counters so that
// saturation is reachable quickly.
module tb_whack_judge;

  logic       clk;
  logic       reset;
  logic [3:0] key;
  logic [3:0] mole_pos;
  logic       mole_up;
  logic       clear;
  logic       hit;
  logic       miss;
  logic [3:0] last_key;
  logic [1:0] score;
  logic [1:0] miss_count;

  int checks = 0;
  int errors = 0;
  int hc = 0;
  int mc = 0;

  whack_judge #(
    .DEBOUNCE_CYCLES(4),
    .NUM_HOLES(9),
    .SCORE_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .mole_pos(mole_pos),
    .mole_up(mole_up),
    .clear(clear),
    .hit(hit),
    .miss(miss),
    .last_key(last_key),
    .score(score),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold key k for n samples, tallying pulses seen after each edge.
  task automatic drive(input logic [3:0] k, input int n);
    key = k;
    repeat (n) begin
      tick();
      if (hit)  hc++;
      if (miss) mc++;
    end
  endtask

  initial begin
    reset = 1'b0; key = 4'd3; mole_up = 1'b1; mole_pos = 4'd3; clear = 1'b0;
    repeat (3) tick();
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_last_key", last_key, 15);
    check("rst_score", score, 0);
    check("rst_miss_count", miss_count, 0);
    key = 4'd15;
    #2 reset = 1'b1;
    hc = 0; mc = 0;
    drive(4'd15, 50);
    check("idle_hits", hc, 0);
    check("idle_misses", mc, 0);

    // Clean hit: pulse on the 4th sample edge
    mole_pos = 4'd5; key = 4'd5;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("latency_hit_edge%0d", i), hit, (i == 4) ? 1 : 0);
    end
    check("clean_score", score, 1);
    check("clean_last_key", last_key, 5);
    hc = 0; mc = 0;
    drive(4'd5, 26);
    check("held_no_repeat_hit", hc, 0);
    check("held_no_repeat_miss", mc, 0);
    drive(4'd15, 6);

    // Bounce: 5,15,5,5,5,5
    hc = 0; mc = 0;
    drive(4'd5, 1); drive(4'd15, 1); drive(4'd5, 3);
    check("bounce_early", hc, 0);
    drive(4'd5, 1);
    check("bounce_hit", hit, 1);
    check("bounce_count", hc, 1);
    check("bounce_score", score, 2);
    drive(4'd15, 6);
    // Candidate switch: 5,6,6,6,6
    mole_pos = 4'd6; hc = 0;
    drive(4'd5, 1); drive(4'd6, 4);
    check("switch_hit", hit, 1);
    check("switch_count", hc, 1);
    check("switch_last_key", last_key, 6);
    check("switch_score", score, 3);
    drive(4'd15, 6);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_score", score, 0);

    // Misses
    mole_pos = 4'd2; hc = 0; mc = 0;
    drive(4'd7, 8);
    check("miss_wrong_hole", mc, 1);
    check("miss_no_hit", hc, 0);
    check("miss_count1", miss_count, 1);
    check("miss_score_kept", score, 0);
    check("miss_last_key", last_key, 7);
    drive(4'd15, 6);
    mole_up = 1'b0;
    drive(4'd2, 8);
    check("miss_mole_down", mc, 2);
    check("miss_count2", miss_count, 2);
    check("miss_down_last_key", last_key, 2);
    drive(4'd15, 6);
    hc = 0; mc = 0;
    drive(4'd12, 10);
    check("invalid_key_hits", hc, 0);
    check("invalid_key_misses", mc, 0);
    check("invalid_key_last", last_key, 2);
    drive(4'd15, 2);

    // Release glitch while holding 5
    mole_up = 1'b1; mole_pos = 4'd5; hc = 0; mc = 0;
    drive(4'd5, 8);
    check("glitch_first_hit", hc, 1);
    check("glitch_first_score", score, 1);
    hc = 0; mc = 0;
    drive(4'd15, 2); drive(4'd5, 1); drive(4'd15, 4);
    check("glitch_no_hit", hc, 0);
    check("glitch_no_miss", mc, 0);
    drive(4'd5, 3);
    check("repress_early", hit, 0);
    drive(4'd5, 1);
    check("repress_hit", hit, 1);
    check("repress_score", score, 2);
    drive(4'd15, 6);

    // Saturation
    drive(4'd5, 4);
    check("sat_score3", score, 3);
    drive(4'd15, 6);
    drive(4'd5, 4);
    check("sat_hit_pulse", hit, 1);
    check("sat_score_hold", score, 3);
    drive(4'd15, 6);
    mole_pos = 4'd2;
    drive(4'd7, 4);
    check("sat_miss3", miss_count, 3);
    drive(4'd15, 6);
    drive(4'd7, 4);
    check("sat_miss_pulse", miss, 1);
    check("sat_miss_hold", miss_count, 3);
    drive(4'd15, 6);

    // Clear on the same edge as a hit
    mole_pos = 4'd5;
    drive(4'd5, 3);
    clear = 1'b1;
    drive(4'd5, 1);
    clear = 1'b0;
    check("clear_hit_pulse", hit, 1);
    check("clear_hit_score", score, 0);
    check("clear_hit_misscnt", miss_count, 0);
    check("clear_keeps_last", last_key, 5);
    drive(4'd15, 6);

    // Reset mid-debounce discards the pending press
    hc = 0; mc = 0;
    drive(4'd5, 2);
    reset = 1'b0;
    #1;
    check("midrst_last_key", last_key, 15);
    check("midrst_hit", hit, 0);
    #2 reset = 1'b1;
    drive(4'd5, 2);
    check("midrst_no_event", hc + mc, 0);
    drive(4'd15, 10);
    check("midrst_after_hits", hc, 0);
    check("midrst_after_misses", mc, 0);
    check("midrst_last_after", last_key, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
